// File: rtl/proj_pkg.sv
`default_nettype none
// ============================================================================
// Package     : proj_pkg
// Description : Shared FSM state type, timing constants and a sizing helper
//               for the single-step push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package proj_pkg;

  // Button conditioner states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } st_e;

  // Default timings at 50 MHz
  localparam int unsigned DEBOUNCE_10MS = 32'd500000;
  localparam int unsigned REPEAT_500MS  = 32'd25000000;
  localparam int unsigned REPEAT_100MS  = 32'd5000000;

  // Largest of three values, used to size the shared counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : STAGES-deep flop synchroniser for a single asynchronous bit,
//               cleared asynchronously by an active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the chain; the last stage is the safe copy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_gen
// Description : Turns the raw single-step button into one-cycle step pulses:
//               synchronise, debounce press and release, emit one pulse per
//               press, optional auto-repeat while held, wrapping pulse count.
// Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_gen
  import proj_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int unsigned REPEAT_DELAY    = REPEAT_500MS,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_100MS,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       BI,
  output logic       OUT,
  output logic       Pressed,
  output logic [7:0] PressCount
);

  localparam int unsigned CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam int unsigned FW = $clog2(SYNC_STAGES + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [FW-1:0] FLUSHED  = FW'(SYNC_STAGES);

  logic          s;
  st_e           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_d;
  logic          out_q;
  logic [7:0]    count_q;
  logic [FW-1:0] flush_q, flush_d;
  logic          armed_q, armed_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (CLK),
    .rst_ni (Reset),
    .d_i    (BI),
    .q_o    (s)
  );

  // After reset the synchroniser holds stale zeros for SYNC_STAGES cycles.
  // Presses are only accepted once a genuinely released button has been
  // seen, so a button held through reset never steps.
  always_comb begin
    flush_d = (flush_q == FLUSHED) ? flush_q : flush_q + FW'(1);
    armed_d = armed_q | ((flush_q == FLUSHED) && !s);
  end

  // Next-state, counter and pulse decode
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        if (s && armed_q) st_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!s) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          st_d    = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          st_d  = RELEASE_DB;
          cnt_d = '0;
        end else if (REPEAT_EN && (cnt_q == RD_LAST)) begin
          st_d    = REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!s) begin
          st_d  = RELEASE_DB;
          cnt_d = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE_DB: begin
        // A bounce back high returns to HELD without stepping again
        if (s) begin
          st_d  = HELD;
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // State, counters, registered pulse and press counter
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      count_q <= 8'd0;
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      out_q   <= pulse_d;
      flush_q <= flush_d;
      armed_q <= armed_d;
      if (pulse_d) count_q <= count_q + 8'd1;
    end
  end

  assign OUT        = out_q;
  assign Pressed    = (st_q == HELD) || (st_q == REPEAT) || (st_q == RELEASE_DB);
  assign PressCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_step_pulse_gen
// Description : Directed self-checking bench for step_pulse_gen with short
//               timings (sync 2, debounce 4, delay 20, period 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bi;
  logic       out1, pr1;
  logic [7:0] cnt1;
  logic       out0, pr0;
  logic [7:0] cnt0;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int q[$];
  int n0 = 0;
  int pr_seen = 0;
  int consec = 0;
  logic prev1 = 1'b0;
  int exp2[4] = '{7, 27, 35, 43};

  always #5 clk = ~clk;

  step_pulse_gen #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8), .REPEAT_EN(1'b1)
  ) dut (
    .CLK(clk), .Reset(rst_n), .BI(bi),
    .OUT(out1), .Pressed(pr1), .PressCount(cnt1)
  );

  step_pulse_gen #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8), .REPEAT_EN(1'b0)
  ) dut_norep (
    .CLK(clk), .Reset(rst_n), .BI(bi),
    .OUT(out0), .Pressed(pr0), .PressCount(cnt0)
  );

  // Advance one edge and log what the outputs did just after it
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (out1 === 1'b1) begin
      q.push_back(edge_n);
      if (prev1 === 1'b1) consec++;
    end
    prev1 = out1;
    if (out0 === 1'b1) n0++;
    if (pr1 === 1'b1) pr_seen++;
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic start();
    edge_n  = 0;
    q.delete();
    n0      = 0;
    pr_seen = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bi    = 1'b0;
    repeat (3) tick();
    chk("rst_out", out1, 1'b0);
    chk("rst_pressed", pr1, 1'b0);
    chk("rst_count", cnt1, 8'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // 1: clean press held 10 cycles
    start();
    bi = 1'b1;
    tick_to(6);
    chk("t1_out_e6", out1, 1'b0);
    chk("t1_pr_e6", pr1, 1'b0);
    tick_to(7);
    chk("t1_out_e7", out1, 1'b1);
    chk("t1_pr_e7", pr1, 1'b1);
    chk("t1_cnt_e7", cnt1, 8'd1);
    tick_to(8);
    chk("t1_out_e8", out1, 1'b0);
    tick_to(10);
    bi = 1'b0;
    tick_to(16);
    chk("t1_pr_e16", pr1, 1'b1);
    tick_to(17);
    chk("t1_pr_e17", pr1, 1'b0);
    tick_to(20);
    chk("t1_npulse", q.size(), 1);

    // 2: long hold with auto-repeat; release lands on a repeat terminal edge
    start();
    bi = 1'b1;
    tick_to(48);
    bi = 1'b0;
    tick_to(54);
    chk("t2_pr_e54", pr1, 1'b1);
    tick_to(55);
    chk("t2_pr_e55", pr1, 1'b0);
    tick_to(60);
    chk("t2_npulse", q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_pulse%0d", i), (q.size() > i) ? q[i] : -1, exp2[i]);
    chk("t2_cnt", cnt1, 8'd5);
    chk("t2_norep_npulse", n0, 1);
    chk("t2_norep_cnt", cnt0, 8'd2);

    // 3: two glitches shorter than the debounce window
    start();
    bi = 1'b1;
    tick_to(3);
    bi = 1'b0;
    tick_to(5);
    bi = 1'b1;
    tick_to(8);
    bi = 1'b0;
    tick_to(20);
    chk("t3_npulse", q.size(), 0);
    chk("t3_pressed_seen", pr_seen, 0);
    chk("t3_cnt", cnt1, 8'd5);

    // 4: release bounce of 2 cycles then clean release
    start();
    bi = 1'b1;
    tick_to(12);
    bi = 1'b0;
    tick_to(14);
    bi = 1'b1;
    tick_to(15);
    chk("t4_pr_e15", pr1, 1'b1);
    tick_to(17);
    chk("t4_pr_e17", pr1, 1'b1);
    tick_to(20);
    bi = 1'b0;
    tick_to(26);
    chk("t4_pr_e26", pr1, 1'b1);
    tick_to(27);
    chk("t4_pr_e27", pr1, 1'b0);
    tick_to(30);
    chk("t4_npulse", q.size(), 1);
    chk("t4_pulse0", (q.size() > 0) ? q[0] : -1, 7);
    chk("t4_cnt", cnt1, 8'd6);
    chk("t4_norep_cnt", cnt0, 8'd3);

    // 5: asynchronous reset while auto-repeating
    start();
    bi = 1'b1;
    tick_to(30);
    chk("t5_pr_before", pr1, 1'b1);
    chk("t5_cnt_before", cnt1, 8'd8);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_out_rst", out1, 1'b0);
    chk("t5_pr_rst", pr1, 1'b0);
    chk("t5_cnt_rst", cnt1, 8'd0);
    chk("t5_norep_cnt_rst", cnt0, 8'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    start();
    tick_to(30);
    chk("t5_held_npulse", q.size(), 0);
    chk("t5_held_pressed", pr_seen, 0);
    bi = 1'b0;
    repeat (10) tick();
    start();
    bi = 1'b1;
    tick_to(6);
    chk("t5_re_out_e6", out1, 1'b0);
    tick_to(7);
    chk("t5_re_out_e7", out1, 1'b1);
    chk("t5_re_cnt", cnt1, 8'd1);
    tick_to(8);
    bi = 1'b0;
    tick_to(25);

    // 6: press counter wrap
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    start();
    for (int p = 0; p < 255; p++) begin
      bi = 1'b1;
      repeat (6) tick();
      bi = 1'b0;
      repeat (8) tick();
    end
    chk("t6_npulse255", q.size(), 255);
    chk("t6_cnt255", cnt1, 8'd255);
    chk("t6_norep_cnt255", cnt0, 8'd255);
    start();
    bi = 1'b1;
    repeat (6) tick();
    bi = 1'b0;
    tick_to(14);
    chk("t6_wrap_npulse", q.size(), 1);
    chk("t6_wrap_pulse0", (q.size() > 0) ? q[0] : -1, 7);
    chk("t6_cnt_wrap", cnt1, 8'd0);
    chk("t6_norep_cnt_wrap", cnt0, 8'd0);

    chk("no_back_to_back", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
